// File: rtl/fir_pkg.sv
// fir_pkg: constants and loader state type shared by the FIR datapath
// wrapper and the coefficient loader.
//   FIR_TAPS       - number of coefficients in the datapath shift chain
//   FIR_WIDTH      - bits per coefficient
//   loader_state_t - coefficient loader FSM states
package fir_pkg;

    localparam int FIR_TAPS  = 4;
    localparam int FIR_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } loader_state_t;

endpackage

// File: rtl/bit_divider.sv
// bit_divider: free-running modulo-DIV counter that sets the serial bit period.
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous active-low reset, clears the count
//   clear - synchronous clear, holds the count at 0 while high
//   tc    - terminal count, high while the count equals DIV-1
module bit_divider #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tc
);

    localparam int              CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear || (count == LAST)) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == LAST);

endmodule

// File: rtl/fir_coef_loader.sv
// fir_coef_loader: accepts a full coefficient set through a valid/ready
// handshake and serialises it, MSB first, onto the FIR datapath's
// coefficient shift chain.
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous active-low reset
//   coef_in    - packed coefficients, c0 in [WIDTH-1:0], c3 in the top WIDTH bits
//   load_valid - host offers coef_in
//   load_ready - loader can accept a set (IDLE only)
//   shift_data - serial bit to the datapath shift input
//   shift_en   - one-cycle strobe, datapath shifts shift_data in
//   busy       - shift in progress, datapath coefficients invalid
//   done       - one-cycle pulse after the last bit has been strobed
module fir_coef_loader
    import fir_pkg::*;
#(
    parameter int WIDTH = FIR_WIDTH,
    parameter int TAPS  = FIR_TAPS,
    parameter int DIV   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [TAPS*WIDTH-1:0] coef_in,
    input  logic                  load_valid,
    output logic                  load_ready,
    output logic                  shift_data,
    output logic                  shift_en,
    output logic                  busy,
    output logic                  done
);

    localparam int             TOTAL    = TAPS * WIDTH;
    localparam int             BW       = $clog2(TOTAL + 1);
    localparam logic [BW-1:0]  LAST_BIT = BW'(TOTAL - 1);

    loader_state_t    state;
    logic [TOTAL-1:0] sreg;
    logic [BW-1:0]    bit_cnt;
    logic             tc;
    logic             handshake;
    logic             strobe;

    assign load_ready = (state == IDLE);
    assign busy       = (state == SHIFT);
    assign done       = (state == DONE);
    assign handshake  = load_valid && load_ready;
    assign strobe     = (state == SHIFT) && tc;
    assign shift_en   = strobe;

    // The register MSB is the line itself. Zeros fill from the bottom, so
    // after the last strobe the register is empty and the line idles at 0
    // in DONE and IDLE without extra gating.
    assign shift_data = sreg[TOTAL-1];

    // Held in clear outside SHIFT, so the first bit period starts at 0 on
    // the cycle after the handshake and the first strobe lands DIV cycles
    // after it.
    bit_divider #(
        .DIV (DIV)
    ) u_bit_divider (
        .clk   (clk),
        .reset (reset),
        .clear (state != SHIFT),
        .tc    (tc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            sreg    <= '0;
            bit_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (handshake) begin
                        // Packed layout already has c3[WIDTH-1] at the top and
                        // c0[0] at the bottom, which is the transmit order.
                        sreg    <= coef_in;
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (strobe) begin
                        sreg    <= {sreg[TOTAL-2:0], 1'b0};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
